// File: rtl/dpram_frame_reader.sv
// rtl/dpram_frame_reader.sv - frame DPRAM read engine: header parse, payload stream, rd_ptr release
module dpram_frame_reader #(
   parameter int ADDR_W  = 11,
   parameter int MAX_LEN = 1518
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_rdata,
   input  logic [ADDR_W:0]   wr_commit,
   output logic [ADDR_W:0]   rd_ptr,
   output logic [7:0]        m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              frame_err,
   output logic              busy
);

   localparam int          PW        = ADDR_W + 1;
   localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

   typedef enum logic [2:0] {
      IDLE,
      HDR_HI,
      HDR_LO,
      HDR_LEN,
      DATA,
      DROP
   } state_t;

   state_t          state;
   logic [PW-1:0]   base;
   logic [7:0]      hdr_hi;
   logic [15:0]     len_r;
   logic [15:0]     rd_cnt;
   logic            pend;
   logic            pend_last;
   logic [7:0]      sk_data;
   logic            sk_valid;
   logic            sk_last;

   logic [15:0]     len_now;
   logic            len_ok;
   logic            pop;
   logic [1:0]      occ;
   logic            space_ok;
   logic            rd_issue;
   logic            pay_issue;
   logic            issue_last;
   logic [PW-1:0]   rd_addr_p;

   assign len_now  = {hdr_hi, ram_rdata};
   assign len_ok   = (len_now != 16'd0) && (len_now <= MAX_LEN_W);
   assign pop      = m_valid & m_ready;
   // Occupancy after this edge; a read issued now lands one edge later, so it must fit then.
   assign occ      = 2'(m_valid) + 2'(sk_valid) + 2'(pend) - 2'(pop);
   assign space_ok = (occ <= 2'd1);
   assign busy     = (state != IDLE);

   always_comb begin
      rd_issue   = 1'b0;
      pay_issue  = 1'b0;
      issue_last = 1'b0;
      rd_addr_p  = base;
      case (state)
         HDR_HI: begin
            rd_issue  = 1'b1;
            rd_addr_p = base;
         end
         HDR_LO: begin
            rd_issue  = 1'b1;
            rd_addr_p = base + PW'(1);
         end
         HDR_LEN: begin
            rd_issue   = len_ok && space_ok;
            pay_issue  = rd_issue;
            issue_last = (len_now == 16'd1);
            rd_addr_p  = base + PW'(2);
         end
         DATA: begin
            rd_issue   = (rd_cnt != len_r) && space_ok;
            pay_issue  = rd_issue;
            issue_last = ((rd_cnt + 16'd1) == len_r);
            rd_addr_p  = base + PW'(2) + PW'(rd_cnt);
         end
         default: begin
            rd_issue = 1'b0;
         end
      endcase
   end

   assign ram_rd_en = rd_issue & ~rst;
   assign ram_addr  = ram_rd_en ? rd_addr_p[ADDR_W-1:0] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         base      <= '0;
         hdr_hi    <= '0;
         len_r     <= '0;
         rd_cnt    <= '0;
         rd_ptr    <= '0;
         frame_err <= 1'b0;
         pend      <= 1'b0;
         pend_last <= 1'b0;
         m_data    <= '0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         sk_data   <= '0;
         sk_valid  <= 1'b0;
         sk_last   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         pend      <= pay_issue;
         pend_last <= pay_issue & issue_last;

         // Main register refills from the skid first so byte order is preserved.
         if (!m_valid || pop) begin
            if (sk_valid) begin
               m_data  <= sk_data;
               m_last  <= sk_last;
               m_valid <= 1'b1;
               if (pend) begin
                  sk_data <= ram_rdata;
                  sk_last <= pend_last;
               end else begin
                  sk_valid <= 1'b0;
               end
            end else if (pend) begin
               m_data  <= ram_rdata;
               m_last  <= pend_last;
               m_valid <= 1'b1;
            end else begin
               m_valid <= 1'b0;
               m_last  <= 1'b0;
            end
         end else if (pend) begin
            sk_data  <= ram_rdata;
            sk_last  <= pend_last;
            sk_valid <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (wr_commit != rd_ptr) begin
                  base  <= rd_ptr;
                  state <= HDR_HI;
               end
            end
            HDR_HI: begin
               state <= HDR_LO;
            end
            HDR_LO: begin
               hdr_hi <= ram_rdata;
               state  <= HDR_LEN;
            end
            HDR_LEN: begin
               len_r  <= len_now;
               rd_cnt <= pay_issue ? 16'd1 : 16'd0;
               if (len_now == 16'd0) begin
                  rd_ptr <= base + PW'(2);
                  state  <= IDLE;
               end else if (len_now > MAX_LEN_W) begin
                  frame_err <= 1'b1;
                  state     <= DROP;
               end else begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (pay_issue) begin
                  rd_cnt <= rd_cnt + 16'd1;
               end
               // Space is released only once the whole frame has left.
               if (pop && m_last) begin
                  rd_ptr <= base + PW'(2) + PW'(len_r);
                  state  <= IDLE;
               end
            end
            DROP: begin
               rd_ptr <= wr_commit;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dpram_frame_reader.sv
// tb/tb_dpram_frame_reader.sv - directed self-checking bench for dpram_frame_reader
module tb_dpram_frame_reader;

   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ram_rd_en;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_rdata = 8'h00;
   logic [AW:0]   wr_commit = '0;
   logic [AW:0]   rd_ptr;
   logic [7:0]    m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic          m_last;
   logic          frame_err;
   logic          busy;

   logic [7:0]    mem [64];
   int            passed = 0;
   int            total = 0;
   int            cyc = 0;
   int            err_cyc = 0;
   int            vld_cyc = 0;
   int            last_cnt = 0;
   logic [8:0]    got [$];
   int            got_cyc [$];

   dpram_frame_reader #(.ADDR_W(AW), .MAX_LEN(1518)) dut (
      .clk       (clk),
      .rst       (rst),
      .ram_rd_en (ram_rd_en),
      .ram_addr  (ram_addr),
      .ram_rdata (ram_rdata),
      .wr_commit (wr_commit),
      .rd_ptr    (rd_ptr),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_rd_en) ram_rdata <= mem[ram_addr];
   end

   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         if (frame_err) err_cyc++;
         if (m_valid) vld_cyc++;
         if (m_valid && m_ready) begin
            got.push_back({m_last, m_data});
            got_cyc.push_back(cyc);
            if (m_last) last_cnt++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      int n;
      int v0;
      int e0;
      int l0;
      logic       s_valid;
      logic       s_ready;
      logic [8:0] s_word;
      logic       pat [4];
      logic [7:0] b;

      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_rd_ptr", rd_ptr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_ram_rd_en", ram_rd_en, 0);

      // len=3 frame at base 0; the next edge samples the commit, m_valid four edges after that
      mem[0] = 8'h00; mem[1] = 8'h03; mem[2] = 8'hAA; mem[3] = 8'hBB; mem[4] = 8'hCC;
      rst = 1'b0;
      m_ready = 1'b1;
      wr_commit = 7'd5;
      n = 0;
      do begin @(negedge clk); n++; end while (!m_valid && n < 20);
      chk("t1_latency", n, 5);
      chk("t1_b0", {m_last, m_data}, {1'b0, 8'hAA});
      @(negedge clk);
      chk("t1_b1", {m_last, m_data}, {1'b0, 8'hBB});
      @(negedge clk);
      chk("t1_b2", {m_last, m_data}, {1'b1, 8'hCC});
      @(negedge clk);
      chk("t1_valid_after", m_valid, 0);
      chk("t1_rd_ptr", rd_ptr, 5);
      chk("t1_busy", busy, 0);

      // zero-length header, then len=1 {7E}
      mem[5] = 8'h00; mem[6] = 8'h00; mem[7] = 8'h00; mem[8] = 8'h01; mem[9] = 8'h7E;
      got.delete();
      v0 = vld_cyc;
      wr_commit = 7'd10;
      n = 0;
      do begin @(negedge clk); n++; end while (rd_ptr == 7'd5 && n < 20);
      chk("t4_skip_rd_ptr", rd_ptr, 7);
      chk("t4_skip_no_valid", vld_cyc - v0, 0);
      n = 0;
      while (!m_valid && n < 20) begin @(negedge clk); n++; end
      chk("t4_byte", {m_last, m_data}, {1'b1, 8'h7E});
      @(negedge clk);
      chk("t4_rd_ptr", rd_ptr, 10);
      chk("t4_count", got.size(), 1);

      // oversize header drops everything committed
      mem[10] = 8'hFF; mem[11] = 8'hFF;
      e0 = err_cyc;
      v0 = vld_cyc;
      wr_commit = 7'd20;
      repeat (12) @(negedge clk);
      chk("t5_err_cycles", err_cyc - e0, 1);
      chk("t5_no_valid", vld_cyc - v0, 0);
      chk("t5_rd_ptr", rd_ptr, 20);
      chk("t5_busy", busy, 0);

      // len=5 with m_ready 1,0,0,1,...; outputs must hold while stalled
      mem[20] = 8'h00; mem[21] = 8'h05;
      for (int i = 0; i < 5; i++) mem[22 + i] = 8'h11 * (i + 1);
      got.delete();
      wr_commit = 7'd27;
      s_valid = 1'b0;
      s_ready = 1'b1;
      s_word  = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (s_valid && !s_ready) begin
            chk("t3_hold_valid", m_valid, 1);
            chk("t3_hold_word", {m_last, m_data}, s_word);
         end
         m_ready = pat[k % 4];
         s_valid = m_valid;
         s_ready = m_ready;
         s_word  = {m_last, m_data};
      end
      m_ready = 1'b1;
      @(negedge clk);
      chk("t3_count", got.size(), 5);
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         b = 8'h11 * (i + 1);
         chk($sformatf("t3_b%0d", i), got[i], {(i == 4), b});
      end
      chk("t3_rd_ptr", rd_ptr, 27);

      // flush to 62 so the next frame straddles the wrap
      mem[27] = 8'hFF; mem[28] = 8'hFF;
      wr_commit = 7'd62;
      repeat (10) @(negedge clk);
      chk("t2_pre_rd_ptr", rd_ptr, 62);

      mem[62] = 8'h00; mem[63] = 8'h04;
      for (int i = 0; i < 4; i++) mem[i] = 8'(i + 1);
      got.delete();
      got_cyc.delete();
      wr_commit = 7'd68;
      repeat (15) @(negedge clk);
      chk("t2_count", got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         b = 8'(i + 1);
         chk($sformatf("t2_b%0d", i), got[i], {(i == 3), b});
      end
      if (got_cyc.size() == 4) chk("t2_no_bubble", got_cyc[3] - got_cyc[0], 3);
      chk("t2_rd_ptr", rd_ptr, 68);

      // 10-byte frame at addr 4, reset while the 2nd byte is on the output
      mem[4] = 8'h00; mem[5] = 8'h0A;
      for (int i = 0; i < 10; i++) mem[6 + i] = 8'(8'h20 + i);
      l0 = last_cnt;
      wr_commit = 7'd80;
      n = 0;
      while (!m_valid && n < 20) begin @(negedge clk); n++; end
      chk("t6_b0", m_data, 8'h20);
      @(negedge clk);
      chk("t6_b1", m_data, 8'h21);
      rst = 1'b1;
      wr_commit = '0;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_valid", m_valid, 0);
      chk("t6_rd_ptr", rd_ptr, 0);
      chk("t6_busy", busy, 0);
      v0 = vld_cyc;
      repeat (20) @(negedge clk);
      chk("t6_no_valid", vld_cyc - v0, 0);
      chk("t6_no_last", last_cnt - l0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
